fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the `ctrl` decoder. It owns the program counter and runs a request/acknowledge handshake with instruction memory. It places each fetched instruction into a one-entry IF/ID slot whose `[31:26]` field drives the decoder `opcode` input. It also resolves jump, branch and `jr` redirects reported back from execute and discards wrong-path fetches.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/branch_resolve.sv | 53 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcode field values, fetch FSM states and
// word-size constants used by the fetch stage and its neighbours.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  // Sequential fetch address; wraps naturally at the top of the address space.
  function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational redirect resolver: decides whether the control-flow
// instruction in execute is taken and where fetch must go next.
module branch_resolve (
  input  logic        ex_valid,
  input  logic        ex_jump,
  input  logic        ex_jr,
  input  logic        ex_branch,
  input  logic        ex_brchne,
  input  logic        ex_bgtz,
  input  logic        ex_blez,
  input  logic        ex_bltz,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jidx,
  input  logic [31:0] ex_pc4,
  output logic        taken,
  output logic [31:0] target
);

  logic signed [31:0] rs_s;
  logic signed [31:0] boff;
  logic               cond;

  assign rs_s = ex_rs;
  assign boff = {{14{ex_imm[15]}}, ex_imm, 2'b00};

  // Class priority resolves the (illegal) case of several classes asserted together.
  always_comb begin
    cond   = 1'b0;
    target = ex_pc4 + $unsigned(boff);
    if (ex_jr) begin
      cond   = 1'b1;
      target = {ex_rs[31:2], 2'b00};
    end else if (ex_jump) begin
      cond   = 1'b1;
      target = {ex_pc4[31:28], ex_jidx, 2'b00};
    end else if (ex_branch) begin
      cond = (ex_rs == ex_rt);
    end else if (ex_brchne) begin
      cond = (ex_rs != ex_rt);
    end else if (ex_bgtz) begin
      cond = (rs_s > 32'sd0);
    end else if (ex_blez) begin
      cond = (rs_s <= 32'sd0);
    end else if (ex_bltz) begin
      cond = (rs_s < 32'sd0);
    end
  end

  assign taken = ex_valid && cond;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory,
// feeds a one-entry IF/ID slot (with skid buffer) and applies execute redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  opcode,
  input  logic        ex_valid,
  input  logic        ex_jump,
  input  logic        ex_jr,
  input  logic        ex_branch,
  input  logic        ex_brchne,
  input  logic        ex_bgtz,
  input  logic        ex_blez,
  input  logic        ex_bltz,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jidx,
  input  logic [31:0] ex_pc4,
  output logic        flush
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc4;
  logic         taken;
  logic [31:0]  target;
  logic         slot_free;

  branch_resolve u_branch_resolve (
    .ex_valid  (ex_valid),
    .ex_jump   (ex_jump),
    .ex_jr     (ex_jr),
    .ex_branch (ex_branch),
    .ex_brchne (ex_brchne),
    .ex_bgtz   (ex_bgtz),
    .ex_blez   (ex_blez),
    .ex_bltz   (ex_bltz),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_imm    (ex_imm),
    .ex_jidx   (ex_jidx),
    .ex_pc4    (ex_pc4),
    .taken     (taken),
    .target    (target)
  );

  assign flush     = taken;
  assign slot_free = !id_valid || id_ready;
  assign imem_addr = pc;
  assign opcode    = id_instr[31:26];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // A redirect while a request is still outstanding must swallow its late ack.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: begin
        if (taken)                        state_nx = imem_ack ? S_FETCH : S_DROP;
        else if (imem_ack && !slot_free)  state_nx = S_STALL;
      end
      S_STALL: if (taken || id_ready)     state_nx = S_FETCH;
      S_DROP:  if (!taken && imem_ack)    state_nx = S_FETCH;
      default:                            state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == S_FETCH) || (state == S_DROP);
  end

  // Skid contents are only meaningful in STALL, so leaving STALL invalidates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc4     <= '0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (taken) begin
      pc       <= target;
      id_valid <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc <= pc_next(pc);
            if (slot_free) begin
              id_valid <= 1'b1;
              id_instr <= imem_rdata;
              id_pc4   <= pc_next(pc);
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= pc_next(pc);
            end
          end else if (id_ready) begin
            id_valid <= 1'b0;
          end
        end
        S_STALL: begin
          if (id_ready) begin
            id_instr <= skid_instr;
            id_pc4   <= skid_pc4;
          end
        end
        default: begin
          if (id_ready) id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run, all
// checked against an instruction-stream reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  opcode;
  logic        ex_valid, ex_jump, ex_jr, ex_branch, ex_brchne, ex_bgtz, ex_blez, ex_bltz;
  logic [31:0] ex_rs, ex_rt, ex_pc4;
  logic [15:0] ex_imm;
  logic [25:0] ex_jidx;
  logic        flush;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc4     (id_pc4),
    .opcode     (opcode),
    .ex_valid   (ex_valid),
    .ex_jump    (ex_jump),
    .ex_jr      (ex_jr),
    .ex_branch  (ex_branch),
    .ex_brchne  (ex_brchne),
    .ex_bgtz    (ex_bgtz),
    .ex_blez    (ex_blez),
    .ex_bltz    (ex_bltz),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_imm     (ex_imm),
    .ex_jidx    (ex_jidx),
    .ex_pc4     (ex_pc4),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Staged stimulus, applied at the next falling edge.
  logic        s_valid;
  int          s_cls;   // 0 none, 1 jr, 2 jump, 3 beq, 4 bne, 5 bgtz, 6 blez, 7 bltz
  logic [31:0] s_rs, s_rt, s_pc4;
  logic [15:0] s_imm;
  logic [25:0] s_jidx;
  logic        s_rdy;
  int          ack_mode; // 0 zero-wait, 1 withhold, 2 random, 3 ack with stale data

  bit          model_on;
  logic [31:0] exp_addr;
  int          accepted;
  logic        prev_wait;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[31:8], a[1:0]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_ex();
    s_valid = 1'b0; s_cls = 0; s_rs = '0; s_rt = '0; s_pc4 = '0; s_imm = '0; s_jidx = '0;
  endtask

  // Redirect outcome derived directly from the architectural rules.
  task automatic ref_redirect(output logic tk, output logic [31:0] tg);
    int signed rs_i;
    rs_i = s_rs;
    tk = 1'b0;
    tg = s_pc4 + 32'(4 * int'($signed(s_imm)));
    case (s_cls)
      1: begin tk = 1'b1; tg = s_rs - (s_rs % 4); end
      2: begin tk = 1'b1; tg = {s_pc4[31:28], s_jidx, 2'b00}; end
      3: tk = (s_rs == s_rt);
      4: tk = (s_rs != s_rt);
      5: tk = (rs_i > 0);
      6: tk = (rs_i <= 0);
      7: tk = (rs_i < 0);
      default: tk = 1'b0;
    endcase
    tk = tk && s_valid;
  endtask

  task automatic cyc();
    logic        m_taken;
    logic [31:0] m_tgt;
    logic [31:0] w;
    @(negedge clk);
    ex_valid  = s_valid;
    ex_jr     = (s_cls == 1);
    ex_jump   = (s_cls == 2);
    ex_branch = (s_cls == 3);
    ex_brchne = (s_cls == 4);
    ex_bgtz   = (s_cls == 5);
    ex_blez   = (s_cls == 6);
    ex_bltz   = (s_cls == 7);
    ex_rs = s_rs; ex_rt = s_rt; ex_pc4 = s_pc4; ex_imm = s_imm; ex_jidx = s_jidx;
    id_ready = s_rdy;
    case (ack_mode)
      1:       imem_ack = 1'b0;
      2:       imem_ack = imem_req && ($urandom_range(0, 1) == 0);
      default: imem_ack = imem_req;
    endcase
    imem_rdata = (ack_mode == 3) ? 32'hDEAD_BEEF : mem_word(imem_addr);
    #1;
    if (model_on) begin
      ref_redirect(m_taken, m_tgt);
      chk("flush", {31'd0, flush}, {31'd0, m_taken});
      if (prev_wait) begin
        chk("req_hold", {31'd0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (m_taken) begin
        exp_addr = m_tgt;
      end else if (id_valid && id_ready) begin
        w = mem_word(exp_addr);
        chk("slot_pc4", id_pc4, exp_addr + 32'd4);
        chk("slot_instr", id_instr, w);
        chk("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
        exp_addr = exp_addr + 32'd4;
        accepted++;
      end
      prev_wait = imem_req && !imem_ack && !m_taken;
      prev_addr = imem_addr;
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    ex_valid = 1'b0; ex_jump = 1'b0; ex_jr = 1'b0; ex_branch = 1'b0; ex_brchne = 1'b0;
    ex_bgtz = 1'b0; ex_blez = 1'b0; ex_bltz = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_pc4 = '0; ex_imm = '0; ex_jidx = '0;
    clr_ex();
    s_rdy = 1'b1; ack_mode = 0; model_on = 1'b0; accepted = 0;
    prev_wait = 1'b0; prev_addr = '0; exp_addr = RPC;

    // Reset state
    cyc();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    cyc();
    rst_n = 1'b1;
    model_on = 1'b1; exp_addr = RPC; prev_wait = 1'b0;

    // Zero-wait streaming
    cyc();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    chk("valid_before_ack", {31'd0, id_valid}, 32'd0);
    cyc();
    w = mem_word(RPC);
    chk("addr_seq1", imem_addr, RPC + 32'd4);
    chk("valid_after_ack", {31'd0, id_valid}, 32'd1);
    chk("opcode_first", {26'd0, opcode}, {26'd0, w[31:26]});
    cyc();
    chk("addr_seq2", imem_addr, RPC + 32'd8);

    // Decode back-pressure: skid capture then STALL with request low
    s_rdy = 1'b0;
    cyc();
    cyc();
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("stall_req2", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, id_valid}, 32'd1);
    s_rdy = 1'b1;
    cyc();
    chk("stall_drain_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    cyc();

    // Taken beq backwards
    s_valid = 1'b1; s_cls = 3; s_rs = 32'd5; s_rt = 32'd5; s_pc4 = 32'h100; s_imm = 16'hFFFE;
    cyc();
    chk("beq_flush", {31'd0, flush}, 32'd1);
    clr_ex();
    cyc();
    chk("beq_target", imem_addr, 32'h0000_00F8);
    chk("beq_slot_killed", {31'd0, id_valid}, 32'd0);

    // Jump while a request is outstanding; late ack carries stale data
    ack_mode = 1;
    s_valid = 1'b1; s_cls = 2; s_pc4 = 32'h3000_0000; s_jidx = 26'h123456;
    cyc();
    chk("jump_flush", {31'd0, flush}, 32'd1);
    clr_ex();
    cyc();
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_pc", imem_addr, 32'h3048_D158);
    chk("drop_valid", {31'd0, id_valid}, 32'd0);
    ack_mode = 3;
    cyc();
    ack_mode = 0;
    cyc();
    chk("jump_target", imem_addr, 32'h3048_D158);
    chk("late_data_dropped", {31'd0, id_valid}, 32'd0);
    cyc();
    chk("jump_slot", id_instr, mem_word(32'h3048_D158));

    // Sign-sensitive branches on the most negative value
    s_valid = 1'b1; s_cls = 7; s_rs = 32'h8000_0000; s_pc4 = 32'h200; s_imm = 16'h0010;
    cyc();
    chk("bltz_flush", {31'd0, flush}, 32'd1);
    clr_ex();
    cyc();
    chk("bltz_target", imem_addr, 32'h0000_0240);
    s_valid = 1'b1; s_cls = 5; s_rs = 32'h8000_0000; s_pc4 = 32'h200; s_imm = 16'h0010;
    cyc();
    chk("bgtz_flush", {31'd0, flush}, 32'd0);
    a = imem_addr;
    clr_ex();
    cyc();
    chk("bgtz_seq", imem_addr, a + 32'd4);

    // jr to the top of memory, then PC wraps to zero
    s_valid = 1'b1; s_cls = 1; s_rs = 32'hFFFF_FFFB;
    cyc();
    chk("jr_flush", {31'd0, flush}, 32'd1);
    clr_ex();
    cyc();
    chk("jr_target", imem_addr, 32'hFFFF_FFF8);
    cyc();
    chk("wrap_m4", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_zero", imem_addr, 32'h0000_0000);

    // Asynchronous reset while stalled
    s_rdy = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_stall", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    model_on = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_instr", id_instr, 32'd0);
    s_rdy = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    model_on = 1'b1; exp_addr = RPC; prev_wait = 1'b0;
    cyc();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RPC);

    // Randomized traffic against the stream model
    accepted = 0;
    ack_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      s_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        s_valid = ($urandom_range(0, 7) != 0);
        s_cls   = $urandom_range(0, 7);
        case ($urandom_range(0, 5))
          0:       s_rs = 32'd5;
          1:       s_rs = 32'h8000_0000;
          2:       s_rs = 32'd0;
          3:       s_rs = 32'h7FFF_FFFF;
          4:       s_rs = 32'hFFFF_FFF4;
          default: s_rs = $urandom;
        endcase
        s_rt   = ($urandom_range(0, 1) == 0) ? s_rs : $urandom;
        s_pc4  = $urandom & 32'hFFFF_FFFC;
        s_imm  = 16'($urandom);
        s_jidx = 26'($urandom);
      end else begin
        clr_ex();
      end
      cyc();
    end
    clr_ex();
    chk("progress", {31'd0, (accepted > 100)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
